// File: rtl/lsu_trigger_ctl.sv
// rtl/lsu_trigger_ctl.sv - LSU debug trigger qualification, fire handshake and hit status
// Chains trigger pairs {0,1}/{2,3}, arbitrates the lowest hit into one pending fire, tracks sticky hits.
module lsu_trigger_ctl (
   input  logic       clk,
   input  logic       rst_l,
   input  logic [3:0] lsu_trigger_match_dc3,
   input  logic       lsu_pkt_valid_dc3,
   input  logic       flush_dc4,
   input  logic [1:0] trigger_chain,
   input  logic [3:0] trigger_action,
   input  logic       trig_ack,
   input  logic       dbg_resume,
   input  logic [3:0] trig_hit_clr,
   output logic [3:0] lsu_trigger_hit_dc4,
   output logic       lsu_trig_fire,
   output logic [1:0] lsu_trig_idx,
   output logic       lsu_trig_action,
   output logic [3:0] lsu_trig_hit_status,
   output logic       lsu_trig_dbg_halt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      DBG  = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] match_dc4;
   logic [3:0] qual_hit;
   logic [3:0] hit_status_q;
   logic [1:0] idx_q;
   logic [1:0] first_idx;
   logic       action_q;
   logic       latch_fire;
   logic       any_hit;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         match_dc4 <= 4'b0;
      end else begin
         match_dc4 <= lsu_trigger_match_dc3 & {4{lsu_pkt_valid_dc3}};
      end
   end

   // A chained trigger only counts when its partner also matched.
   always_comb begin
      qual_hit    = 4'b0;
      qual_hit[0] = match_dc4[0] & (~trigger_chain[0] | match_dc4[1]);
      qual_hit[1] = match_dc4[1] & (~trigger_chain[0] | match_dc4[0]);
      qual_hit[2] = match_dc4[2] & (~trigger_chain[1] | match_dc4[3]);
      qual_hit[3] = match_dc4[3] & (~trigger_chain[1] | match_dc4[2]);
   end

   assign lsu_trigger_hit_dc4 = qual_hit & ~{4{flush_dc4}};
   assign any_hit             = |lsu_trigger_hit_dc4;

   always_comb begin
      first_idx = 2'd3;
      if (lsu_trigger_hit_dc4[0]) begin
         first_idx = 2'd0;
      end else if (lsu_trigger_hit_dc4[1]) begin
         first_idx = 2'd1;
      end else if (lsu_trigger_hit_dc4[2]) begin
         first_idx = 2'd2;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      latch_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_hit) begin
               state_d    = PEND;
               latch_fire = 1'b1;
            end
         end
         PEND: begin
            if (trig_ack) begin
               state_d = action_q ? DBG : IDLE;
            end
         end
         DBG: begin
            if (dbg_resume) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // idx/action are captured only on the IDLE->PEND edge so later hits cannot disturb them.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         idx_q    <= 2'd0;
         action_q <= 1'b0;
      end else if (latch_fire) begin
         idx_q    <= first_idx;
         action_q <= trigger_action[first_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hit_status_q <= 4'b0;
      end else begin
         hit_status_q <= (hit_status_q & ~trig_hit_clr) | lsu_trigger_hit_dc4;
      end
   end

   assign lsu_trig_fire       = (state_q == PEND);
   assign lsu_trig_dbg_halt   = (state_q == DBG);
   assign lsu_trig_idx        = (state_q == IDLE) ? 2'd0 : idx_q;
   assign lsu_trig_action     = (state_q == IDLE) ? 1'b0 : action_q;
   assign lsu_trig_hit_status = hit_status_q;

endmodule
